// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants and helpers for the counter, clock and FND blocks.
// Words are carried at the widest legal size (8 digits) and zero-extended.
package bcd_updown_counter_pkg;

    localparam int NIBBLE_W = 4;
    localparam int MAX_DIGITS = 8;
    localparam logic [NIBBLE_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef logic [NIBBLE_W*MAX_DIGITS-1:0] bcd_word_t;

    function automatic logic bcd_is_valid(input bcd_word_t v, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && v[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Valid packed BCD orders exactly like binary, most significant digit first.
    function automatic logic bcd_le(input bcd_word_t a, input bcd_word_t b);
        return a <= b;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit step: +1 or -1 when enabled by the lower digits.
// Rolling past 9 or below 0 raises carry/borrow for the next digit.
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_i,
    input  logic                inc,
    input  logic                dec,
    input  logic                carry_in,
    input  logic                borrow_in,
    output logic [NIBBLE_W-1:0] digit_o,
    output logic                carry_out,
    output logic                borrow_out
);

    always_comb begin
        digit_o    = digit_i;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (inc && carry_in) begin
            if (digit_i == BCD_MAX_DIGIT) begin
                digit_o   = '0;
                carry_out = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (dec && borrow_in) begin
            if (digit_i == '0) begin
                digit_o    = BCD_MAX_DIGIT;
                borrow_out = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Loadable up/down packed-BCD counter with wrap/saturate terminal handling.
// tc and load_err are registered so tc can tick the next stage directly.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int                    DIGITS   = 2,
    parameter logic [4*DIGITS-1:0]   MAX_BCD  = 'h59,
    parameter bit                    SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                clk_time,
    input  logic                up_down,
    input  logic                load_enable,
    input  logic [4*DIGITS-1:0] set_value,
    input  logic                clear,
    output logic [4*DIGITS-1:0] dec,
    output logic                tc,
    output logic                load_err,
    output logic                is_zero
);

    localparam int W = NIBBLE_W * DIGITS;
    localparam bcd_word_t MAX_WIDE = bcd_word_t'(MAX_BCD);

    logic [W-1:0]  dec_q, dec_d;
    logic [W-1:0]  step_val;
    logic          tc_q, tc_d;
    logic          err_q, err_d;
    logic [DIGITS:0] carry, borrow;
    logic          unused_chain;
    bcd_word_t     set_wide;
    logic          load_ok;
    logic          at_max, at_zero;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;
    assign unused_chain = carry[DIGITS] ^ borrow[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit_i   (dec_q[g*NIBBLE_W +: NIBBLE_W]),
            .inc       (up_down),
            .dec       (~up_down),
            .carry_in  (carry[g]),
            .borrow_in (borrow[g]),
            .digit_o   (step_val[g*NIBBLE_W +: NIBBLE_W]),
            .carry_out (carry[g+1]),
            .borrow_out(borrow[g+1])
        );
    end

    always_comb begin
        set_wide = '0;
        set_wide[W-1:0] = set_value;
    end

    assign load_ok = bcd_is_valid(set_wide, DIGITS) && bcd_le(set_wide, MAX_WIDE);
    assign at_max  = (dec_q == MAX_BCD);
    assign at_zero = (dec_q == '0);

    always_comb begin
        dec_d = dec_q;
        tc_d  = 1'b0;
        err_d = 1'b0;
        if (clear) begin
            dec_d = '0;
        end else if (load_enable) begin
            if (load_ok) begin
                dec_d = set_value;
            end else begin
                err_d = 1'b1;
            end
        end else if (clk_time) begin
            if (up_down) begin
                if (at_max) begin
                    if (!SATURATE) begin
                        dec_d = '0;
                        tc_d  = 1'b1;
                    end
                end else begin
                    dec_d = step_val;
                    tc_d  = SATURATE && (step_val == MAX_BCD);
                end
            end else begin
                if (at_zero) begin
                    if (!SATURATE) begin
                        dec_d = MAX_BCD;
                        tc_d  = 1'b1;
                    end
                end else begin
                    dec_d = step_val;
                    tc_d  = SATURATE && (step_val == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            dec_q <= '0;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign dec      = dec_q;
    assign tc       = tc_q;
    assign load_err = err_q;
    assign is_zero  = at_zero;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: vector table, scoreboard queue and
// hand-written wrap, countdown, async reset and sec/min cascade runs.
module tb_bcd_updown_counter;

    typedef struct {
        int          dut;
        logic        clr;
        logic        ld;
        logic [11:0] sv;
        logic        tick;
        logic        ud;
        logic [11:0] dec;
        logic        tc;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic reset_p;
    always #5 clk = ~clk;

    // A: 2 digits, 'h59, wrap.  B: 2 digits, 'h23, wrap.  C: 3 digits, 'h999, saturate.
    logic       a_clr, a_ld, a_tick, a_ud;
    logic [7:0] a_sv, dec_a;
    logic       tc_a, err_a, zero_a;
    logic       b_clr, b_ld, b_tick, b_ud;
    logic [7:0] b_sv, dec_b;
    logic       tc_b, err_b, zero_b;
    logic       c_clr, c_ld, c_tick, c_ud;
    logic [11:0] c_sv, dec_c;
    logic       tc_c, err_c, zero_c;
    logic       cas_tick;
    logic [7:0] dec_s, dec_m;
    logic       tc_s, err_s, zero_s, tc_m, err_m, zero_m;

    int errors = 0;
    int checks = 0;
    vec_t sb[$];
    vec_t tbl[$];

    bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset_p(reset_p), .clk_time(a_tick), .up_down(a_ud),
        .load_enable(a_ld), .set_value(a_sv), .clear(a_clr),
        .dec(dec_a), .tc(tc_a), .load_err(err_a), .is_zero(zero_a));

    bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h23), .SATURATE(1'b0)) u_b (
        .clk(clk), .reset_p(reset_p), .clk_time(b_tick), .up_down(b_ud),
        .load_enable(b_ld), .set_value(b_sv), .clear(b_clr),
        .dec(dec_b), .tc(tc_b), .load_err(err_b), .is_zero(zero_b));

    bcd_updown_counter #(.DIGITS(3), .MAX_BCD(12'h999), .SATURATE(1'b1)) u_c (
        .clk(clk), .reset_p(reset_p), .clk_time(c_tick), .up_down(c_ud),
        .load_enable(c_ld), .set_value(c_sv), .clear(c_clr),
        .dec(dec_c), .tc(tc_c), .load_err(err_c), .is_zero(zero_c));

    bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .SATURATE(1'b0)) u_sec (
        .clk(clk), .reset_p(reset_p), .clk_time(cas_tick), .up_down(1'b1),
        .load_enable(1'b0), .set_value(8'h00), .clear(1'b0),
        .dec(dec_s), .tc(tc_s), .load_err(err_s), .is_zero(zero_s));

    bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .SATURATE(1'b0)) u_min (
        .clk(clk), .reset_p(reset_p), .clk_time(tc_s), .up_down(1'b1),
        .load_enable(1'b0), .set_value(8'h00), .clear(1'b0),
        .dec(dec_m), .tc(tc_m), .load_err(err_m), .is_zero(zero_m));

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic vec_t mk(input int dut, input logic clr, input logic ld,
                                input logic [11:0] sv, input logic tick, input logic ud,
                                input logic [11:0] d, input logic t, input logic e);
        vec_t v;
        v.dut = dut; v.clr = clr; v.ld = ld; v.sv = sv; v.tick = tick;
        v.ud = ud; v.dec = d; v.tc = t; v.err = e;
        return v;
    endfunction

    task automatic cmp(input string nm, input int id, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", nm, id, $time, act, exp);
        end
    endtask

    task automatic drive_idle();
        a_clr = 0; a_ld = 0; a_tick = 0; a_ud = 1; a_sv = '0;
        b_clr = 0; b_ld = 0; b_tick = 0; b_ud = 1; b_sv = '0;
        c_clr = 0; c_ld = 0; c_tick = 0; c_ud = 1; c_sv = '0;
    endtask

    task automatic check_out();
        vec_t e;
        logic [11:0] d;
        logic t, er, z;
        e = sb.pop_front();
        case (e.dut)
            0: begin d = {4'h0, dec_a}; t = tc_a; er = err_a; z = zero_a; end
            1: begin d = {4'h0, dec_b}; t = tc_b; er = err_b; z = zero_b; end
            default: begin d = dec_c; t = tc_c; er = err_c; z = zero_c; end
        endcase
        cmp("dec", e.dut, 16'(d), 16'(e.dec));
        cmp("tc", e.dut, 16'(t), 16'(e.tc));
        cmp("load_err", e.dut, 16'(er), 16'(e.err));
        cmp("is_zero", e.dut, 16'(z), 16'(e.dec == 12'h000));
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        case (v.dut)
            0: begin a_clr = v.clr; a_ld = v.ld; a_sv = v.sv[7:0];
                     a_tick = v.tick; a_ud = v.ud; end
            1: begin b_clr = v.clr; b_ld = v.ld; b_sv = v.sv[7:0];
                     b_tick = v.tick; b_ud = v.ud; end
            default: begin c_clr = v.clr; c_ld = v.ld; c_sv = v.sv;
                     c_tick = v.tick; c_ud = v.ud; end
        endcase
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_out();
        drive_idle();
    endtask

    initial begin
        int sec_m, min_m, sec_tcs, min_tcs;
        logic pend;
        logic [11:0] es, em;

        reset_p = 1'b1;
        cas_tick = 1'b0;
        drive_idle();
        #12;
        cmp("rst_dec_a", 0, 16'(dec_a), 16'h0);
        cmp("rst_tc_a", 0, 16'(tc_a), 16'h0);
        cmp("rst_err_a", 0, 16'(err_a), 16'h0);
        cmp("rst_zero_a", 0, 16'(zero_a), 16'h1);
        cmp("rst_dec_c", 2, 16'(dec_c), 16'h0);
        @(negedge clk);
        reset_p = 1'b0;

        // 60 up ticks on A: 'h01..'h59 then 'h00 with tc
        for (int i = 1; i <= 60; i++)
            apply(mk(0, 0, 0, 0, 1, 1, to_bcd(i % 60), i == 60, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 12'h000, 0, 0));
        apply(mk(0, 0, 0, 0, 1, 0, 12'h059, 1, 0));
        apply(mk(0, 0, 0, 0, 1, 0, 12'h058, 0, 0));
        apply(mk(0, 0, 0, 0, 1, 1, 12'h059, 0, 0));
        apply(mk(0, 0, 0, 0, 1, 1, 12'h000, 1, 0));

        // Priority, validation and non-uniform terminal
        tbl.push_back(mk(0, 0, 1, 12'h037, 0, 1, 12'h037, 0, 0));
        tbl.push_back(mk(0, 1, 1, 12'h042, 1, 1, 12'h000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 12'h042, 1, 1, 12'h042, 0, 0));
        tbl.push_back(mk(0, 0, 1, 12'h04A, 0, 1, 12'h042, 0, 1));
        tbl.push_back(mk(0, 0, 1, 12'h060, 0, 1, 12'h042, 0, 1));
        tbl.push_back(mk(0, 0, 0, 12'h000, 1, 0, 12'h041, 0, 0));
        tbl.push_back(mk(0, 1, 0, 12'h000, 0, 1, 12'h000, 0, 0));
        tbl.push_back(mk(1, 0, 1, 12'h019, 0, 1, 12'h019, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 1, 1, 12'h020, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 1, 1, 12'h021, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 1, 1, 12'h022, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 1, 1, 12'h023, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 1, 1, 12'h000, 1, 0));
        tbl.push_back(mk(1, 0, 1, 12'h024, 0, 1, 12'h000, 0, 1));
        tbl.push_back(mk(1, 0, 1, 12'h023, 0, 1, 12'h023, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 1, 0, 12'h022, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h000, 0, 0, 12'h022, 0, 0));
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Saturating countdown on C
        apply(mk(2, 0, 1, 12'h100, 0, 0, 12'h100, 0, 0));
        for (int k = 1; k <= 100; k++)
            apply(mk(2, 0, 0, 0, 1, 0, to_bcd(100 - k), k == 100, 0));
        apply(mk(2, 0, 0, 0, 1, 0, 12'h000, 0, 0));
        apply(mk(2, 0, 1, 12'h998, 0, 1, 12'h998, 0, 0));
        apply(mk(2, 0, 0, 0, 1, 1, 12'h999, 1, 0));
        apply(mk(2, 0, 0, 0, 1, 1, 12'h999, 0, 0));
        apply(mk(2, 0, 0, 0, 1, 0, 12'h998, 0, 0));

        // Async reset between edges
        apply(mk(0, 0, 1, 12'h037, 0, 1, 12'h037, 0, 0));
        @(negedge clk);
        #2;
        reset_p = 1'b1;
        #1;
        cmp("async_dec_a", 0, 16'(dec_a), 16'h0);
        cmp("async_zero_a", 0, 16'(zero_a), 16'h1);
        cmp("async_dec_c", 2, 16'(dec_c), 16'h0);
        @(negedge clk);
        reset_p = 1'b0;
        apply(mk(0, 0, 0, 0, 1, 1, 12'h001, 0, 0));

        // sec -> min cascade, one tick per cycle
        sec_m = 0; min_m = 0; pend = 0; sec_tcs = 0; min_tcs = 0;
        for (int n = 0; n <= 3600; n++) begin
            @(negedge clk);
            cas_tick = (n < 3600);
            @(posedge clk);
            if (pend) min_m = (min_m + 1) % 60;
            pend = cas_tick && (sec_m == 59);
            if (cas_tick) sec_m = (sec_m + 1) % 60;
            #1;
            es = to_bcd(sec_m);
            em = to_bcd(min_m);
            cmp("cascade", 3, {dec_m, dec_s}, {em[7:0], es[7:0]});
            if (tc_s) sec_tcs++;
            if (tc_m) min_tcs++;
        end
        cas_tick = 1'b0;
        cmp("sec_tc_count", 3, 16'(sec_tcs), 16'd60);
        cmp("min_tc_count", 4, 16'(min_tcs), 16'd1);
        cmp("cas_zero", 3, {14'h0, zero_m, zero_s}, 16'h3);
        cmp("cas_err", 3, {14'h0, err_m, err_s}, 16'h0);
        cmp("sb_empty", 0, 16'(sb.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

- Parametrised, loadable, up/down packed-BCD counter that generalises the team's fixed mod-60/mod-100 counters.
- Any digit count, any BCD terminal value, wrap or saturate mode, registered terminal-count pulse for cascading.
- Sits downstream of the clock dividers: takes their one-cycle tick pulses and feeds FND/clock/timer logic.
- Cascaded instances build sec/min/hour chains, countdown timers and distance readouts.

## Interface

Parameters:
- DIGITS, default 2: number of BCD digits; legal range 1..8.
- MAX_BCD, default 'h59: terminal value in packed BCD, 4*DIGITS bits; every nibble must be ≤9.
- SATURATE, default 0: 0 = wrap at the bounds, 1 = stop at the bounds (timer mode).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset_p  in  1  asynchronous, active-high reset.
- clk_time  in  1  count tick, one-cycle pulse at the clk rate.
- up_down  in  1  count direction: 1 = up, 0 = down; sampled on the tick.
- load_enable  in  1  synchronous load of set_value.
- set_value  in  4*DIGITS  packed-BCD load value.
- clear  in  1  synchronous clear to 0.
- dec  out  4*DIGITS  packed-BCD count; digit 0 is bits [3:0]. Registered.
- tc  out  1  terminal-count pulse, one cycle. Registered.
- load_err  out  1  one-cycle pulse when a load is rejected. Registered.
- is_zero  out  1  high when dec == 0. Combinational from the dec register.

## Operation

- Reset values: dec = 0, tc = 0, load_err = 0.
- Per-cycle priority: clear > load_enable > clk_time. A lower-priority event in the same cycle is dropped, not deferred.
- clear: dec ← 0.
- Load:
  - A load is valid when every nibble of set_value is ≤9 and set_value ≤ MAX_BCD (BCD magnitude compare). Valid load: dec ← set_value.
  - Invalid load: dec holds, load_err pulses.
- Up tick:
  - If dec == MAX_BCD: SATURATE=0 → dec ← 0, tc=1; SATURATE=1 → dec holds, tc=0.
  - Otherwise dec ← BCD(dec+1): digit i increments only if all lower digits are 9; digits that were 9 roll to 0.
  - SATURATE=1 only: tc=1 on the tick whose result equals MAX_BCD.
- Down tick:
  - If dec == 0: SATURATE=0 → dec ← MAX_BCD, tc=1; SATURATE=1 → dec holds, tc=0.
  - Otherwise dec ← BCD(dec−1): digits that were 0 become 9.
  - SATURATE=1 only: tc=1 on the tick whose result is 0. This is the countdown "done" event.
- tc is 0 in every cycle without a qualifying tick, and is 0 on load/clear cycles.
- dec never holds a non-BCD nibble or a value > MAX_BCD.
- Changing up_down between ticks is legal; the next tick uses the new direction.
- The comparison against MAX_BCD is full-width, so non-uniform terminals such as 'h23 (hours) and 'h12 behave correctly: 'h19 → 'h20, and 'h23 wraps to 'h00.

## Timing

- Latency: dec and tc update on the clk edge that samples the event. The new value is visible the cycle after the tick is presented.
- tc is high in exactly the cycle in which dec first shows the wrapped/terminal value.
- tc may drive the next stage's clk_time directly. The chain adds one cycle of latency per stage, with no combinational ripple.
- A tick on every clk cycle is supported: one step per cycle, no lost counts.
- reset_p asserted mid-count clears all outputs asynchronously. The first tick after release counts from 0.
- is_zero follows dec combinationally within the same cycle.

## Structure

- Shared include file holds the BCD constants (BCD_MAX_DIGIT=9, nibble width 4) and the bcd_is_valid / BCD compare functions. These are reused by the clock/FND blocks.
- Sub-module bcd_digit: one 4-bit digit with inc, dec, carry_in/borrow_in and carry_out/borrow_out. It is instantiated DIGITS times in a generate loop.
- Top level: MAX/zero compare, load validation, priority mux, tc/load_err registers.

## Test plan

- Wrap up: DIGITS=2, MAX_BCD='h59, SATURATE=0; 60 up ticks from 0 → dec steps 'h00..'h59 then 'h00; tc is high only in the cycle showing 'h00.
- Non-uniform terminal: MAX_BCD='h23; load 'h19 then 5 up ticks → 'h20,'h21,'h22,'h23,'h00; tc on 'h00. Load 'h24 → load_err pulse, dec holds 'h00.
- Countdown saturate: DIGITS=3, MAX_BCD='h999, SATURATE=1; load 'h100, down ticks → 'h099 … 'h001, 'h000 with tc and is_zero=1; a further tick keeps 'h000 with tc=0.
- Priority: clear + load('h42) + tick in one cycle → 'h00. Load('h42) + tick → 'h42, no tc. Invalid nibble 'h4A → load_err, dec unchanged.
- Cascade: two DIGITS=2 instances (sec 'h59 → min 'h59) with a tick every cycle; after 3600 ticks both read 'h00, the min tc fires once, and there are no missed or double counts.
- Async reset: assert reset_p between edges at dec='h37 → dec=0 immediately; the first post-release up tick gives 'h01.
